occupancy_light_ctrl: RTL and testbench

Multi-zone occupancy lighting controller. Each zone turns its light on when motion is detected and turns it off after a runtime-programmable number of timebase ticks with no motion. Before switch-off, each zone enters an optional pre-off warning phase so the fixture can dim or blink. The block also provides per-zone manual force-on and force-off overrides, and it sits between the motion-sensor synchronisers and the lamp drivers.

---
 rtl/occupancy_light_ctrl.sv | 160 ++++++++++++++++
 tb/tb_occupancy_light_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/occupancy_light_ctrl.sv
// ---------------------------------------------------------------------------
// occupancy_light_ctrl
//
// Multi-zone occupancy lighting controller. Each zone switches its lamp on
// when motion is seen. After a programmable number of timebase ticks with no
// motion, the zone turns the lamp off. An optional pre-off warning phase lets
// the fixture dim or blink before switch-off. Per-zone force-on and force-off
// inputs override the automatic behaviour.
//
// Parameters
//   NUM_ZONES : number of independent zones (>=1)
//   PRESCALE  : clk cycles per timebase tick (>=1)
//   TIMER_W   : width of per-zone tick counter and timeout/warn_ticks
//
// Ports
//   clk            in   system clock, all state on rising edge
//   rst_n          in   asynchronous active-low reset
//   motion         in   per-zone motion level (already synchronised)
//   timeout        in   no-motion ticks before off (0 behaves as 1)
//   warn_ticks     in   warning phase length in ticks (0 = no warning)
//   force_on       in   per-zone manual hold-on
//   force_off      in   per-zone manual hold-off (highest priority)
//   light_on       out  per-zone lamp enable
//   warn           out  per-zone warning phase (dim/blink request)
//   any_on         out  OR of light_on
//   zone_state_dbg out  packed per-zone FSM state, zone z at [2z+1:2z]
//                       (00 OFF, 01 ON, 10 WARN)
//
// Handshake: there is none. All inputs are levels sampled on every rising
// edge, and every output is decoded directly from registered state. An input
// change is therefore visible on the outputs one clock later.
// ---------------------------------------------------------------------------
module occupancy_light_ctrl #(
  parameter int NUM_ZONES = 4,
  parameter int PRESCALE  = 60,
  parameter int TIMER_W   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_ZONES-1:0]   motion,
  input  logic [TIMER_W-1:0]     timeout,
  input  logic [TIMER_W-1:0]     warn_ticks,
  input  logic [NUM_ZONES-1:0]   force_on,
  input  logic [NUM_ZONES-1:0]   force_off,
  output logic [NUM_ZONES-1:0]   light_on,
  output logic [NUM_ZONES-1:0]   warn,
  output logic                   any_on,
  output logic [2*NUM_ZONES-1:0] zone_state_dbg
);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_WARN = 2'd2;

  // A prescaler of 1 still needs a 1-bit register so the code stays uniform.
  localparam int             PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [TIMER_W-1:0] CNT_MAX = {TIMER_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Shared timebase
  // ---------------------------------------------------------------------------
  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;

  always_comb begin
    tick = (ps_q == PS_MAX);
    ps_d = tick ? '0 : ps_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ps_q <= '0;
    else        ps_q <= ps_d;
  end

  // ---------------------------------------------------------------------------
  // Shared thresholds. A timeout of 0 is treated as 1, so a zone always stays
  // lit until at least one tick after motion stops. Warning only makes sense
  // when it is strictly shorter than the effective timeout.
  // ---------------------------------------------------------------------------
  logic [TIMER_W-1:0] t_eff;
  logic [TIMER_W-1:0] w_thr;
  logic               warn_en;

  always_comb begin
    t_eff   = (timeout == '0) ? TIMER_W'(1) : timeout;
    warn_en = (warn_ticks != '0) && (warn_ticks < t_eff);
    w_thr   = t_eff - warn_ticks;
  end

  // ---------------------------------------------------------------------------
  // Per-zone FSM and idle-tick counter
  // ---------------------------------------------------------------------------
  logic [1:0]         state_q [NUM_ZONES];
  logic [1:0]         state_d [NUM_ZONES];
  logic [TIMER_W-1:0] cnt_q   [NUM_ZONES];
  logic [TIMER_W-1:0] cnt_d   [NUM_ZONES];
  logic [TIMER_W-1:0] cnt_nxt [NUM_ZONES];

  always_comb begin
    for (int z = 0; z < NUM_ZONES; z++) begin
      state_d[z] = state_q[z];
      cnt_d[z]   = cnt_q[z];
      // Saturating increment. In practice the counter never reaches
      // CNT_MAX, because the zone turns off first, but the guard keeps a
      // wrap-around impossible.
      cnt_nxt[z] = (cnt_q[z] == CNT_MAX) ? cnt_q[z] : cnt_q[z] + 1'b1;

      if (force_off[z]) begin
        state_d[z] = ST_OFF;
        cnt_d[z]   = '0;
      end else if (force_on[z] || motion[z]) begin
        // Holding force_on keeps the counter at 0. When force_on is released,
        // a full timeout therefore starts from that point.
        state_d[z] = ST_ON;
        cnt_d[z]   = '0;
      end else if (tick && (state_q[z] != ST_OFF)) begin
        if (cnt_nxt[z] >= t_eff) begin
          // This branch also catches a timeout that was lowered below the
          // current count.
          state_d[z] = ST_OFF;
          cnt_d[z]   = '0;
        end else if (warn_en && (cnt_nxt[z] >= w_thr)) begin
          state_d[z] = ST_WARN;
          cnt_d[z]   = cnt_nxt[z];
        end else begin
          cnt_d[z]   = cnt_nxt[z];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int z = 0; z < NUM_ZONES; z++) begin
        state_q[z] <= ST_OFF;
        cnt_q[z]   <= '0;
      end
    end else begin
      for (int z = 0; z < NUM_ZONES; z++) begin
        state_q[z] <= state_d[z];
        cnt_q[z]   <= cnt_d[z];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from registered state. Because of this, an asynchronous
  // reset clears them immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int z = 0; z < NUM_ZONES; z++) begin
      light_on[z]             = (state_q[z] != ST_OFF);
      warn[z]                 = (state_q[z] == ST_WARN);
      zone_state_dbg[2*z +: 2] = state_q[z];
    end
    any_on = |light_on;
  end

endmodule

// File: tb/tb_occupancy_light_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for occupancy_light_ctrl (NUM_ZONES=4, PRESCALE=4, TIMER_W=3).
// The reference model tracks each zone as "lit / warning / idle ticks since
// last activity" with plain integers. A compare process checks the DUT
// against that model on every falling edge. Directed sequences pin the model
// to hand-computed tick timings. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_occupancy_light_ctrl;

  localparam int NZ = 4;
  localparam int PS = 4;
  localparam int TW = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NZ-1:0] motion = '0;
  logic [NZ-1:0] force_on = '0;
  logic [NZ-1:0] force_off = '0;
  logic [TW-1:0] timeout = 3'd5;
  logic [TW-1:0] warn_ticks = 3'd2;
  logic [NZ-1:0] light_on;
  logic [NZ-1:0] warn;
  logic          any_on;
  logic [2*NZ-1:0] zone_state_dbg;

  always #5 clk = ~clk;

  occupancy_light_ctrl #(.NUM_ZONES(NZ), .PRESCALE(PS), .TIMER_W(TW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .motion         (motion),
    .timeout        (timeout),
    .warn_ticks     (warn_ticks),
    .force_on       (force_on),
    .force_off      (force_off),
    .light_on       (light_on),
    .warn           (warn),
    .any_on         (any_on),
    .zone_state_dbg (zone_state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_ps = 0;
  int m_idle [NZ];
  bit m_on   [NZ];
  bit m_warn [NZ];
  bit m_tick;
  int m_t, m_wt;
  bit m_wen;

  initial begin
    for (int z = 0; z < NZ; z++) begin
      m_idle[z] = 0; m_on[z] = 0; m_warn[z] = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ps = 0;
      for (int z = 0; z < NZ; z++) begin
        m_idle[z] = 0; m_on[z] = 0; m_warn[z] = 0;
      end
    end else begin
      m_tick = (m_ps == PS - 1);
      m_ps   = (m_ps + 1) % PS;
      m_t    = (timeout == 0) ? 1 : int'(timeout);
      m_wt   = int'(warn_ticks);
      m_wen  = (m_wt > 0) && (m_wt < m_t);
      for (int z = 0; z < NZ; z++) begin
        if (force_off[z]) begin
          m_on[z] = 0; m_warn[z] = 0; m_idle[z] = 0;
        end else if (force_on[z] || motion[z]) begin
          m_on[z] = 1; m_warn[z] = 0; m_idle[z] = 0;
        end else if (m_tick && m_on[z]) begin
          m_idle[z] = m_idle[z] + 1;
          if (m_idle[z] >= m_t) begin
            m_on[z] = 0; m_warn[z] = 0; m_idle[z] = 0;
          end else if (m_wen && m_idle[z] >= m_t - m_wt) begin
            m_warn[z] = 1;
          end
        end
      end
    end
  end

  // ---------------- compare process ----------------
  logic [NZ-1:0] exp_l, exp_w;
  always @(negedge clk) begin
    for (int z = 0; z < NZ; z++) begin
      exp_l[z] = m_on[z];
      exp_w[z] = m_warn[z];
    end
    check("light_on", 8'(light_on), 8'(exp_l));
    check("warn",     8'(warn),     8'(exp_w));
    check("any_on",   8'(any_on),   8'(|exp_l));
  end

  // ---------------- driver tasks ----------------
  // Entered with rst_n low. Releases reset and pulses motion[0] for one
  // cycle, then stops at the falling edge after edge 12 (third tick, warn up).
  task automatic pulse_from_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    motion = 4'b0001;
    @(negedge clk);                       // after edge 1
    check("lit_on_after_pulse", 8'(light_on), 8'h01);
    motion = '0;
    repeat (10) @(negedge clk);           // after edge 11
    check("lit_no_warn_before_tick3", 8'(warn), 8'h00);
    @(negedge clk);                       // after edge 12
    check("lit_warn_at_tick3", 8'(warn), 8'h01);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);

    // Single pulse: warning at tick 3, off at tick 5.
    pulse_from_reset();
    idle_cycles(7);                       // after edge 19
    check("lit_on_before_tick5", 8'(light_on), 8'h01);
    idle_cycles(1);                       // after edge 20
    check("lit_off_at_tick5", 8'(light_on), 8'h00);
    check("lit_warn_off_at_tick5", 8'(warn), 8'h00);

    // Asynchronous reset in the middle of WARN.
    rst_n = 1'b0;
    pulse_from_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("lit_async_rst_light", 8'(light_on), 8'h00);
    check("lit_async_rst_warn",  8'(warn),     8'h00);
    check("lit_async_rst_any",   8'(any_on),   8'h00);

    // After reset, the prescaler restarts from 0, so the same timing recurs.
    // Motion is applied again one cycle after warn rises.
    pulse_from_reset();
    @(negedge clk);                       // after edge 13
    motion = 4'b0001;
    @(negedge clk);                       // after edge 14
    check("lit_repulse_warn_clr", 8'(warn), 8'h00);
    check("lit_repulse_lit", 8'(light_on), 8'h01);
    motion = '0;
    idle_cycles(17);                      // after edge 31
    check("lit_repulse_on_before", 8'(light_on), 8'h01);
    idle_cycles(1);                       // after edge 32
    check("lit_repulse_off", 8'(light_on), 8'h00);

    // force_off beats motion.
    force_off = 4'b0010;
    motion    = 4'b0010;
    idle_cycles(20);
    check("lit_force_off", 8'(light_on[1]), 8'h00);
    force_off = '0;
    motion    = '0;
    idle_cycles(30);

    // force_on for 50 ticks: lit with no warning, then a full timeout.
    force_on = 4'b0010;
    idle_cycles(200);
    check("lit_force_on_lit",  8'(light_on[1]), 8'h01);
    check("lit_force_on_warn", 8'(warn[1]),     8'h00);
    force_on = '0;
    idle_cycles(30);

    // Warning disabled via 0 and via >= timeout.
    warn_ticks = 3'd0;
    motion = 4'b0001; idle_cycles(1); motion = '0; idle_cycles(30);
    warn_ticks = 3'd5;
    motion = 4'b0001; idle_cycles(1); motion = '0; idle_cycles(30);

    // timeout=0 turns off at the first tick after motion drops.
    timeout = 3'd0;
    motion = 4'b0100; idle_cycles(3); motion = '0; idle_cycles(10);

    // Maximum timeout with staggered zones.
    timeout = 3'd7; warn_ticks = 3'd3;
    motion = 4'b0001; idle_cycles(1); motion = '0; idle_cycles(9);
    motion = 4'b0100; idle_cycles(1); motion = '0; idle_cycles(40);

    // Randomized phase.
    for (int c = 0; c < 4000; c++) begin
      if (c % 150 == 0) begin
        timeout    = 3'($urandom_range(0, 7));
        warn_ticks = 3'($urandom_range(0, 7));
      end
      for (int z = 0; z < NZ; z++) begin
        motion[z] = ($urandom_range(0, 99) < 4);
        if ($urandom_range(0, 199) == 0) force_on[z]  = ~force_on[z];
        if ($urandom_range(0, 299) == 0) force_off[z] = ~force_off[z];
      end
      if (c == 2500) begin
        @(posedge clk);
        #3 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
